// File: rtl/stereo_pan_mixer.sv
// Applies a slew-limited pan position to a mono sample, producing a stereo pair.
// One shared signed multiplier computes the left gain product, then the right one.
module stereo_pan_mixer #(
  parameter logic [15:0] SLEW_STEP = 16'h0040
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] SAMPLE_IN,
  input  logic        SAMPLE_VALID,
  input  logic [15:0] PAN_IN,
  output logic [15:0] LEFT_OUT,
  output logic [15:0] RIGHT_OUT,
  output logic        OUT_VALID,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SLEW  = 3'd1;
  localparam logic [2:0] S_MUL_L = 3'd2;
  localparam logic [2:0] S_MUL_R = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [14:0] PAN_CENTRE = 15'h4000;

  logic [2:0]  r_state;
  logic [15:0] r_sample;
  logic [14:0] r_target;
  logic [14:0] r_pan;
  logic [15:0] r_hold_l;

  logic signed [16:0] w_diff;
  logic [16:0]        w_mag;
  logic [16:0]        w_step;
  logic [14:0]        w_pan_next;
  logic [14:0]        w_gain;
  logic signed [31:0] w_prod;
  logic [15:0]        w_res;
  logic               w_unused_prod;

  assign BUSY = (r_state != S_IDLE);

  // Targets and P are both within 0..0x7FFF, so a 17-bit difference cannot overflow.
  assign w_diff = $signed({2'b00, r_target}) - $signed({2'b00, r_pan});
  assign w_mag  = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
  assign w_step = {1'b0, SLEW_STEP};

  always_comb begin
    w_pan_next = r_target;
    if ((SLEW_STEP != 16'h0000) && (w_mag > w_step)) begin
      // Step is smaller than |d| <= 0x7FFF here, so it fits in 15 bits.
      if (!w_diff[16]) w_pan_next = r_pan + SLEW_STEP[14:0];
      else             w_pan_next = r_pan - SLEW_STEP[14:0];
    end
  end

  assign w_gain = (r_state == S_MUL_L) ? (15'h7FFF - r_pan) : r_pan;
  assign w_prod = $signed({{16{r_sample[15]}}, r_sample}) * $signed({17'd0, w_gain});
  assign w_res  = w_prod[30:15];
  assign w_unused_prod = ^{w_prod[31], w_prod[14:0]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_sample  <= 16'h0000;
      r_target  <= PAN_CENTRE;
      r_pan     <= PAN_CENTRE;
      r_hold_l  <= 16'h0000;
      LEFT_OUT  <= 16'h0000;
      RIGHT_OUT <= 16'h0000;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (SAMPLE_VALID && (r_state != S_IDLE)) OVERRUN <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (SAMPLE_VALID) begin
            r_sample <= SAMPLE_IN;
            r_target <= PAN_IN[15] ? 15'h0000 : PAN_IN[14:0];
            r_state  <= S_SLEW;
          end
        end
        S_SLEW: begin
          r_pan   <= w_pan_next;
          r_state <= S_MUL_L;
        end
        S_MUL_L: begin
          r_hold_l <= w_res;
          r_state  <= S_MUL_R;
        end
        S_MUL_R: begin
          // Both channels and the strobe land on the same edge.
          LEFT_OUT  <= r_hold_l;
          RIGHT_OUT <= w_res;
          OUT_VALID <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// Scoreboard bench for stereo_pan_mixer: default-slew instance A and SLEW_STEP=0 instance B.
module tb_stereo_pan_mixer;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [15:0] a_si = '0, a_pi = '0, a_l, a_r;
  logic        a_sv = 1'b0, a_ov, a_busy, a_orun;
  logic [15:0] b_si = '0, b_pi = '0, b_l, b_r;
  logic        b_sv = 1'b0, b_ov, b_busy, b_orun;

  exp_t q_a[$];
  exp_t q_b[$];

  stereo_pan_mixer u_dut_a (
    .Clk(Clk), .Reset(Reset), .SAMPLE_IN(a_si), .SAMPLE_VALID(a_sv), .PAN_IN(a_pi),
    .LEFT_OUT(a_l), .RIGHT_OUT(a_r), .OUT_VALID(a_ov), .BUSY(a_busy), .OVERRUN(a_orun)
  );

  stereo_pan_mixer #(.SLEW_STEP(16'h0000)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .SAMPLE_IN(b_si), .SAMPLE_VALID(b_sv), .PAN_IN(b_pi),
    .LEFT_OUT(b_l), .RIGHT_OUT(b_r), .OUT_VALID(b_ov), .BUSY(b_busy), .OVERRUN(b_orun)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    a_sv = 1'b0;
    b_sv = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ticks(2);
    Reset = 1'b0;
    tick();
  endtask

  task automatic drive_a(input logic [15:0] s, input logic [15:0] p, input bit push,
                         input logic [15:0] el, input logic [15:0] er);
    a_si = s;
    a_pi = p;
    a_sv = 1'b1;
    if (push) q_a.push_back('{l: el, r: er, cyc: cyc + 4});
  endtask

  task automatic drive_b(input logic [15:0] s, input logic [15:0] p,
                         input logic [15:0] el, input logic [15:0] er);
    b_si = s;
    b_pi = p;
    b_sv = 1'b1;
    q_b.push_back('{l: el, r: er, cyc: cyc + 4});
  endtask

  // Monitors: every OUT_VALID pulse must match the oldest expectation, including its cycle.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge Clk);
      if (a_ov === 1'b1) begin
        total++;
        if (q_a.size() == 0) begin
          bad++;
          $display("FAIL a_unexpected_valid cycle=%0d actual L=%h R=%h required no pulse",
                   cyc, a_l, a_r);
        end else begin
          e = q_a.pop_front();
          if (a_l !== e.l || a_r !== e.r || cyc != e.cyc) begin
            bad++;
            $display("FAIL a_result actual L=%h R=%h cycle=%0d required L=%h R=%h cycle=%0d",
                     a_l, a_r, cyc, e.l, e.r, e.cyc);
          end
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge Clk);
      if (b_ov === 1'b1) begin
        total++;
        if (q_b.size() == 0) begin
          bad++;
          $display("FAIL b_unexpected_valid cycle=%0d actual L=%h R=%h required no pulse",
                   cyc, b_l, b_r);
        end else begin
          e = q_b.pop_front();
          if (b_l !== e.l || b_r !== e.r || cyc != e.cyc) begin
            bad++;
            $display("FAIL b_result actual L=%h R=%h cycle=%0d required L=%h R=%h cycle=%0d",
                     b_l, b_r, cyc, e.l, e.r, e.cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    int c0;
    logic [15:0] exp_r[5];
    logic [15:0] exp_l[5];
    exp_r = '{16'h403F, 16'h407F, 16'h40BF, 16'h40FF, 16'h40FF};
    exp_l = '{16'h3FBE, 16'h3F7E, 16'h3F3E, 16'h3EFE, 16'h3EFE};

    // Reset values.
    #2;
    @(negedge Clk);
    check("rst_left", a_l, 16'h0000);
    check("rst_right", a_r, 16'h0000);
    check("rst_valid", {15'd0, a_ov}, 16'd0);
    check("rst_busy", {15'd0, a_busy}, 16'd0);
    check("rst_overrun", {15'd0, a_orun}, 16'd0);
    check("rst_b_busy", {15'd0, b_busy}, 16'd0);
    do_reset();

    // Centre pan, latency and BUSY window.
    c0 = cyc;
    drive_a(16'h4000, 16'h4000, 1'b1, 16'h1FFF, 16'h2000);
    @(negedge Clk);
    check("s1_busy_c0", {15'd0, a_busy}, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge Clk);
      check("s1_busy_run", {15'd0, a_busy}, 16'd1);
    end
    tick();
    @(negedge Clk);
    check("s1_busy_c5", {15'd0, a_busy}, 16'd0);
    ticks(2);
    check("s1_hold_left", a_l, 16'h1FFF);
    check("s1_hold_right", a_r, 16'h2000);

    // No slew: hard pans and clamping of a negative pan.
    drive_b(16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFE);
    ticks(6);
    drive_b(16'hC000, 16'h0000, 16'hC000, 16'h0000);
    ticks(6);
    drive_b(16'h1000, 16'h9000, 16'h0FFF, 16'h0000);
    ticks(6);

    // Default slew towards 0x4100, five strobes 8 cycles apart.
    for (int k = 0; k < 5; k++) begin
      drive_a(16'h7FFF, 16'h4100, 1'b1, exp_l[k], exp_r[k]);
      ticks(8);
    end

    // Overrun: second strobe two cycles after the first is dropped.
    do_reset();
    c0 = cyc;
    drive_a(16'h4000, 16'h4000, 1'b1, 16'h1FFF, 16'h2000);
    ticks(2);
    drive_a(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h0000);
    @(negedge Clk);
    check("ovr_before", {15'd0, a_orun}, 16'd0);
    tick();
    @(negedge Clk);
    check("ovr_set", {15'd0, a_orun}, 16'd1);
    ticks(2);
    // Cycle c0+5: FSM has just re-entered IDLE.
    drive_a(16'h4000, 16'h4000, 1'b1, 16'h1FFF, 16'h2000);
    ticks(7);
    check("ovr_sticky", {15'd0, a_orun}, 16'd1);

    // Reset mid-operation discards the in-flight sample.
    drive_a(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h0000);
    ticks(2);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_left", a_l, 16'h0000);
    check("mid_rst_right", a_r, 16'h0000);
    check("mid_rst_busy", {15'd0, a_busy}, 16'd0);
    check("mid_rst_overrun", {15'd0, a_orun}, 16'd0);
    tick();
    Reset = 1'b0;
    ticks(6);
    drive_a(16'h4000, 16'h4000, 1'b1, 16'h1FFF, 16'h2000);
    ticks(8);

    check("q_a_drained", 16'(q_a.size()), 16'd0);
    check("q_b_drained", 16'(q_b.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
